// File: rtl/sprite_rom_pkg.sv
// Shared sizes and types for the sprite ROM arbiter and its round-robin grant logic.
package sprite_rom_pkg;

    localparam int NUM_REQ = 4;
    localparam int COORD_W = 6;
    localparam int COLOR_W = 12;
    localparam int ROM_LAT = 2;

    typedef logic [NUM_REQ-1:0] req_vec_t;
    typedef logic [COORD_W-1:0] coord_t;
    typedef logic [COLOR_W-1:0] color_t;

    // Pointer width; a single requester still gets a 1-bit pointer.
    function automatic int ptr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sprite_rom_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr_i, wrapping.
module rr_arbiter
    import sprite_rom_pkg::ptr_w;
#(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = ptr_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [PTR_W-1:0]   ptr_i,
    input  logic               enable_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [PTR_W-1:0]   idx_o
);

    int               cand;
    logic [PTR_W-1:0] cand_idx;
    logic             found;

    always_comb begin
        grant_o  = '0;
        idx_o    = '0;
        found    = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = int'(ptr_i) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            cand_idx = PTR_W'(cand);
            if (enable_i && !found && req_i[cand_idx]) begin
                grant_o[cand_idx] = 1'b1;
                idx_o             = cand_idx;
                found             = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sprite_rom_arbiter.sv
// Shares one two-cycle sprite ROM among NUM_REQ renderers; tags follow each read so the
// returned color is steered back to its requester with a one-hot strobe.
module sprite_rom_arbiter
    import sprite_rom_pkg::ptr_w;
#(
    parameter int NUM_REQ = sprite_rom_pkg::NUM_REQ,
    parameter int COORD_W = sprite_rom_pkg::COORD_W,
    parameter int COLOR_W = sprite_rom_pkg::COLOR_W,
    parameter int ROM_LAT = sprite_rom_pkg::ROM_LAT
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       enable,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*COORD_W-1:0] req_x,
    input  logic [NUM_REQ*COORD_W-1:0] req_y,
    output logic                       rom_en,
    output logic [COORD_W-1:0]         rom_x,
    output logic [COORD_W-1:0]         rom_y,
    input  logic [COLOR_W-1:0]         rom_color,
    output logic [NUM_REQ-1:0]         rsp_valid,
    output logic [COLOR_W-1:0]         rsp_color
);

    localparam int PTR_W = ptr_w(NUM_REQ);

    // Handshake: a request transfers on a clock edge where req_valid[i] & req_ready[i];
    // req_ready is one-hot (or zero) and may depend on req_valid; no response backpressure.
    logic [NUM_REQ-1:0] grant;
    logic [PTR_W-1:0]   gnt_idx;
    logic               xfer;

    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [COORD_W-1:0] rom_x_q, rom_x_d;
    logic [COORD_W-1:0] rom_y_q, rom_y_d;
    logic [NUM_REQ-1:0] tag_q [ROM_LAT];
    logic [NUM_REQ-1:0] rsp_q;
    logic               in_flight;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr_arbiter (
        .req_i    (req_valid),
        .ptr_i    (ptr_q),
        .enable_i (enable),
        .grant_o  (grant),
        .idx_o    (gnt_idx)
    );

    assign xfer = |grant;

    always_comb begin
        ptr_d   = ptr_q;
        rom_x_d = rom_x_q;
        rom_y_d = rom_y_q;
        if (xfer) begin
            ptr_d   = (gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
            rom_x_d = req_x[int'(gnt_idx)*COORD_W +: COORD_W];
            rom_y_d = req_y[int'(gnt_idx)*COORD_W +: COORD_W];
        end
    end

    // Tag stages track the ROM's address and output registers; rsp_q lines up with
    // the cycle in which rom_color holds the data for that tag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q   <= '0;
            rom_x_q <= '0;
            rom_y_q <= '0;
            rsp_q   <= '0;
            for (int s = 0; s < ROM_LAT; s++) begin
                tag_q[s] <= '0;
            end
        end else begin
            ptr_q    <= ptr_d;
            rom_x_q  <= rom_x_d;
            rom_y_q  <= rom_y_d;
            tag_q[0] <= grant;
            for (int s = 1; s < ROM_LAT; s++) begin
                tag_q[s] <= tag_q[s-1];
            end
            rsp_q <= tag_q[ROM_LAT-1];
        end
    end

    always_comb begin
        in_flight = |rsp_q;
        for (int s = 0; s < ROM_LAT; s++) begin
            in_flight = in_flight | (|tag_q[s]);
        end
    end

    assign rom_en    = enable | in_flight;
    assign req_ready = grant;
    assign rom_x     = rom_x_q;
    assign rom_y     = rom_y_q;
    assign rsp_valid = rsp_q;
    assign rsp_color = rom_color;

endmodule
